cordic_atan2: RTL

- Inverse companion to the forward sine/cosine CORDIC path: takes a Q15 (cos, sin) vector and returns its angle atan2(sin, cos) in radians as an IEEE-754 single.
- Iterative vectoring-mode CORDIC with quadrant pre-rotation, followed by an exact fixed-to-float pack.
- Consumes results of the Q15 trig path (round-trip checking, phase recovery); same start/valid handshake style.

---
 rtl/cordic_pkg.sv | 41 ++++
 rtl/fixed_to_ieee754.sv | 32 +++
 rtl/cordic_atan2.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and arctangent table for the vectoring CORDIC.
package cordic_pkg;

  localparam int unsigned Z_W    = 18;
  localparam int unsigned XY_W   = 18;
  localparam int unsigned ATAN_N = 16;

  localparam logic signed [Z_W-1:0] PI_Q      = 18'sd102944;
  localparam logic signed [Z_W-1:0] HALF_PI_Q = 18'sd51472;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_PACK = 2'd2
  } state_t;

  // round(atan(2^-i) * 2^15)
  function automatic logic signed [Z_W-1:0] atan_q15(input logic [3:0] idx);
    logic signed [Z_W-1:0] v;
    case (idx)
      4'd0:    v = 18'sd25736;
      4'd1:    v = 18'sd15193;
      4'd2:    v = 18'sd8027;
      4'd3:    v = 18'sd4075;
      4'd4:    v = 18'sd2045;
      4'd5:    v = 18'sd1024;
      4'd6:    v = 18'sd512;
      4'd7:    v = 18'sd256;
      4'd8:    v = 18'sd128;
      4'd9:    v = 18'sd64;
      4'd10:   v = 18'sd32;
      4'd11:   v = 18'sd16;
      4'd12:   v = 18'sd8;
      4'd13:   v = 18'sd4;
      4'd14:   v = 18'sd2;
      default: v = 18'sd1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fixed_to_ieee754.sv
// Combinational signed Q3.15 radians to IEEE-754 single; exact, since |z| < 2^17
// always fits the 24-bit significand.
module fixed_to_ieee754
  import cordic_pkg::*;
(
  input  logic signed [Z_W-1:0] i_z,
  output logic        [31:0]    o_f
);

  logic        w_sign;
  logic [16:0] w_mag;
  logic [4:0]  w_pos;
  logic [7:0]  w_exp;
  logic [22:0] w_mag_ext;
  logic [22:0] w_frac;

  always_comb begin
    w_sign = i_z[Z_W-1];
    w_mag  = w_sign ? 17'(-i_z) : 17'(i_z);
    w_pos  = '0;
    for (int unsigned b = 0; b < 17; b++) begin
      if (w_mag[b]) w_pos = 5'(b);
    end
    w_exp     = 8'd112 + {3'b000, w_pos};
    w_mag_ext = {6'd0, w_mag};
    // Hidden leading one lands on bit 23 and falls off the 23-bit result.
    w_frac    = w_mag_ext << (5'd23 - w_pos);
    if (w_mag == '0) o_f = '0;
    else             o_f = {w_sign, w_exp, w_frac};
  end

endmodule

// File: rtl/cordic_atan2.sv
// Iterative vectoring-mode CORDIC: Q15 (cos, sin) in, atan2 in radians out as
// an IEEE-754 single, one micro-rotation per clock.
module cordic_atan2
  import cordic_pkg::*;
#(
  parameter int unsigned ITERATIONS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] cos_q15,
  input  logic [15:0] sin_q15,
  output logic [31:0] angle_ieee754,
  output logic        valid,
  output logic        busy
);

  state_t                 r_state;
  logic signed [XY_W-1:0] r_x;
  logic signed [XY_W-1:0] r_y;
  logic signed [Z_W-1:0]  r_z;
  logic [3:0]             r_iter;
  logic [15:0]            r_cos;
  logic [15:0]            r_sin;
  logic [31:0]            r_angle;
  logic                   r_valid;
  logic                   r_busy;

  logic signed [XY_W-1:0] w_cos_ext;
  logic signed [XY_W-1:0] w_sin_ext;
  logic signed [XY_W-1:0] w_x0;
  logic signed [XY_W-1:0] w_y0;
  logic signed [Z_W-1:0]  w_z0;
  logic [15:0]            w_abs_c;
  logic [15:0]            w_abs_s;
  logic [15:0]            w_mag;
  logic [3:0]             w_lead;
  logic [3:0]             w_norm;
  logic signed [XY_W-1:0] w_xs;
  logic signed [XY_W-1:0] w_ys;
  logic signed [Z_W-1:0]  w_atan;
  logic signed [Z_W-1:0]  w_z_final;
  logic [31:0]            w_f;

  always_comb begin
    w_cos_ext = {{(XY_W-16){cos_q15[15]}}, cos_q15};
    w_sin_ext = {{(XY_W-16){sin_q15[15]}}, sin_q15};
    if (cos_q15[15]) begin
      w_x0 = -w_cos_ext;
      w_y0 = -w_sin_ext;
      w_z0 = sin_q15[15] ? -PI_Q : PI_Q;
    end else begin
      w_x0 = w_cos_ext;
      w_y0 = w_sin_ext;
      w_z0 = '0;
    end
    // Scale tiny vectors up so shift truncation cannot dominate the residual angle.
    w_abs_c = cos_q15[15] ? (~cos_q15 + 16'd1) : cos_q15;
    w_abs_s = sin_q15[15] ? (~sin_q15 + 16'd1) : sin_q15;
    w_mag   = w_abs_c | w_abs_s;
    w_lead  = '0;
    for (int unsigned b = 0; b < 16; b++) begin
      if (w_mag[b]) w_lead = 4'(b);
    end
    w_norm = (w_lead < 4'd14) ? (4'd14 - w_lead) : 4'd0;
  end

  always_comb begin
    w_xs   = r_x >>> r_iter;
    w_ys   = r_y >>> r_iter;
    w_atan = atan_q15(r_iter);
  end

  always_comb begin
    w_z_final = r_z;
    if (r_sin == '0) begin
      w_z_final = r_cos[15] ? PI_Q : '0;
    end else if (r_cos == '0) begin
      w_z_final = r_sin[15] ? -HALF_PI_Q : HALF_PI_Q;
    end
  end

  fixed_to_ieee754 u_pack (
    .i_z (w_z_final),
    .o_f (w_f)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_iter  <= '0;
      r_cos   <= '0;
      r_sin   <= '0;
      r_angle <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cos   <= cos_q15;
            r_sin   <= sin_q15;
            r_x     <= w_x0 <<< w_norm;
            r_y     <= w_y0 <<< w_norm;
            r_z     <= w_z0;
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_ROT;
          end
        end
        ST_ROT: begin
          if (!r_y[XY_W-1]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan;
          end
          if (r_iter == 4'(ITERATIONS - 1)) r_state <= ST_PACK;
          else                              r_iter  <= r_iter + 4'd1;
        end
        ST_PACK: begin
          r_angle <= w_f;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign angle_ieee754 = r_angle;
  assign valid         = r_valid;
  assign busy          = r_busy;

endmodule
